reg_watch_logger: RTL and testbench
===================================

Name: reg_watch_logger

Overview:
- Parametrised register-watch logger for the multi-cycle CPU debug path.
- Watches N_CH architectural register taps (a0, v0, sp, ra and more), each DATA_W bits wide.
- Detects value changes and timestamps each change with a free-running cycle counter.
- Queues change events in a FIFO and drains them over a valid/ready stream. Bench scoreboards and on-board debug read from that stream.

Parameters:
- DATA_W, 16, width of each watched register.
- N_CH, 4, number of watched channels; 2..16.
- DEPTH, 8, event FIFO depth; power of two, at least 2.
- TS_W, 16, timestamp width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  logging enable
- ch_data  input  N_CH*DATA_W  packed taps; channel i occupies bits [i*DATA_W +: DATA_W]
- ch_mask  input  N_CH  per-channel watch enable
- ev_valid  output  1  event available
- ev_ready  input  1  consumer accepts event
- ev_chan  output  $clog2(N_CH)  channel index of the event
- ev_data  output  DATA_W  new register value
- ev_ts  output  TS_W  cycle stamp at detection
- drop_cnt  output  8  events lost; saturates at 255
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous) clears all state:
  - outputs: ev_valid=0, ev_chan=0, ev_data=0, ev_ts=0, drop_cnt=0, fifo_level=0
  - internal: FSM=IDLE, snapshot registers=0, pending bits=0, timestamp counter=0
- Timestamp counter:
  - Increments every cycle in which the FSM is not IDLE.
  - Wraps modulo 2^TS_W.
  - Clears on reset only.
- FSM states:
  - IDLE: snapshot follows ch_data every cycle; no detection; FIFO may still drain. enable=1 -> ARM.
  - ARM: lasts one cycle; loads snapshot; no events; -> RUN.
  - RUN: detection active. enable=0 -> IDLE; pending bits are cleared and FIFO contents are kept.
- Detection in RUN, per channel i, when ch_mask[i]=1 and ch_data[i] differs from snapshot[i]:
  - Set pending[i] and latch value and ts into the pending slot.
  - Update snapshot[i].
  - If pending[i] was already set, overwrite the slot (newest value wins) and increment drop_cnt.
- Push arbiter:
  - Each cycle, the lowest-index pending channel is pushed into the FIFO if the FIFO is not full; its pending bit clears.
  - At most one push per cycle.
  - A channel that changes in the same cycle it is pushed re-sets pending with the new value. The pushed entry carries the old slot contents.
- Latency: a change sampled at edge k is pushed at edge k+1 at the earliest. ev_valid rises after edge k+1, i.e. 1 cycle of detection plus 1 cycle of FIFO registration.
- Stream:
  - ev_chan, ev_data and ev_ts show the FIFO head.
  - The head is popped on the edge where ev_valid && ev_ready.
  - When ev_valid=0, the outputs hold their last value.
- Full FIFO: pending bits wait; the overflow is only counted at the pending-slot level.
- Simultaneous push and pop when full: both happen and the level is unchanged.
- Simultaneous push and pop when empty: the push goes through. ev_valid is raised the next cycle; the FIFO has no fall-through path.
- Masking: ch_mask deasserted clears that channel's pending bit; its snapshot keeps tracking.
- Reset asserted mid-drain: all events are discarded immediately and ev_valid falls asynchronously.

Decomposition:
- Package rwl_pkg holds:
  - function clog2
  - FSM state encoding: IDLE=2'd0, ARM=2'd1, RUN=2'd2
  - event record layout: {chan, ts, data}
  - drop_cnt width constant
- Sub-module rwl_fifo:
  - synchronous FIFO of width $clog2(N_CH)+TS_W+DATA_W and depth DEPTH
  - ports: clk, reset, push, din, full, pop, dout, empty, level
- The top level holds the FSM, snapshots, pending slots, arbiter and counters.

Test Plan:
- Basic change: reset 100ns, enable=1, ev_ready=1, raise a0 from 0x0000 to 0x0005 at ts=10 -> one event {chan=0, data=0x0005, ts=10}; drop_cnt=0.
- Simultaneous changes: v0->0x1234, sp->0x7FFC and ra->0x0040 in the same cycle -> events emitted in order chan 1, 2, 3, each one cycle apart, all with the same ts.
- Overwrite loss: hold ev_ready=0 with DEPTH=2. Change channel 0 four times -> FIFO holds the first two values, the pending slot holds the fourth, drop_cnt=1. Release ready -> three events drain.
- Mask and disable: ch_mask=4'b1110, change a0 -> no event. enable=0 then change sp -> no event. Re-enable -> ARM cycle produces no event even though sp differs from the old snapshot.
- Wrap and saturation: TS_W=4, run 20 cycles -> ts wraps 15->0. Force 300 overwrites -> drop_cnt=255.
- Reset mid-drain: 3 events queued, pulse reset -> ev_valid=0 and fifo_level=0 immediately; after release, no stale event appears.

Source files
------------

// File: rtl/rwl_pkg.sv
// Shared types and helpers for the register-watch logger.
// Event records are packed as {chan, ts, data}, chan in the MSBs.
package rwl_pkg;

    localparam int unsigned DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Ceiling log2, with clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned ev_width(input int unsigned chan_w,
                                             input int unsigned ts_w,
                                             input int unsigned data_w);
        return chan_w + ts_w + data_w;
    endfunction

endpackage

// File: rtl/rwl_fifo.sv
// Synchronous event FIFO with a registered head: dout holds its last value
// while empty, and a push into an empty FIFO becomes visible one cycle later.
module rwl_fifo
    import rwl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    output logic                   full,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  level
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d, rd_nxt_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push_c, do_pop_c;

    always_comb begin
        do_pop_c  = pop && !empty_q;
        do_push_c = push && (!full_q || do_pop_c);
        rd_nxt_c  = rd_q + PTR_W'(1);
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        dout_d    = dout_q;
        if (do_push_c) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (do_pop_c) rd_d = rd_nxt_c;
        cnt_d   = cnt_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_W'(DEPTH));
        // Head register follows whichever entry becomes the head after this edge.
        if (do_push_c && (empty_q || (do_pop_c && cnt_q == CNT_W'(1)))) begin
            dout_d = din;
        end else if (do_pop_c && cnt_q > CNT_W'(1)) begin
            dout_d = mem_q[rd_nxt_c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            dout_q  <= dout_d;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign dout  = dout_q;
    assign level = cnt_q;

endmodule

// File: rtl/reg_watch_logger.sv
// Register-watch logger: detects changes on masked register taps, stamps them
// with a cycle counter and streams them out through an event FIFO.
module reg_watch_logger
    import rwl_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_CH   = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TS_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_CH*DATA_W-1:0]  ch_data,
    input  logic [N_CH-1:0]         ch_mask,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [clog2(N_CH)-1:0]  ev_chan,
    output logic [DATA_W-1:0]       ev_data,
    output logic [TS_W-1:0]         ev_ts,
    output logic [DROP_W-1:0]       drop_cnt,
    output logic [clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned CH_W  = clog2(N_CH);
    localparam int unsigned EV_W  = ev_width(CH_W, TS_W, DATA_W);
    localparam int unsigned SUM_W = DROP_W + 1;

    state_e            state_q, state_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [DATA_W-1:0] snap_q [N_CH];
    logic [DATA_W-1:0] snap_d [N_CH];
    logic [DATA_W-1:0] slot_data_q [N_CH];
    logic [DATA_W-1:0] slot_data_d [N_CH];
    logic [TS_W-1:0]   slot_ts_q [N_CH];
    logic [TS_W-1:0]   slot_ts_d [N_CH];
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              detect_c, push_c, pop_c;
    logic [CH_W-1:0]   sel_c;
    logic [EV_W-1:0]   push_ev_c;
    logic [N_CH-1:0]   changed_c, taken_c;
    logic [SUM_W-1:0]  drop_sum_c, drop_tot_c;
    logic              fifo_full, fifo_empty;
    logic [EV_W-1:0]   fifo_dout;

    // Mode FSM and timestamp counter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = ARM;
            ARM:     state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ts_d = (state_q == IDLE) ? ts_q : ts_q + TS_W'(1);
    end

    // Change detection, pending slots, push arbitration and loss counting.
    always_comb begin
        detect_c = (state_q == RUN) && enable;
        pop_c    = !fifo_empty && ev_ready;
        sel_c    = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (pend_q[i]) sel_c = CH_W'(i);
        end
        push_c      = (|pend_q) && (!fifo_full || pop_c);
        push_ev_c   = {sel_c, slot_ts_q[sel_c], slot_data_q[sel_c]};
        pend_d      = pend_q;
        slot_data_d = slot_data_q;
        slot_ts_d   = slot_ts_q;
        changed_c   = '0;
        taken_c     = '0;
        drop_sum_c  = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            // Snapshot always ends up equal to the tap, whether tracking or detecting.
            snap_d[i]    = ch_data[i*DATA_W +: DATA_W];
            changed_c[i] = detect_c && ch_mask[i] &&
                           (ch_data[i*DATA_W +: DATA_W] != snap_q[i]);
            taken_c[i]   = push_c && (sel_c == CH_W'(i));
            if (taken_c[i]) pend_d[i] = 1'b0;
            if (changed_c[i]) begin
                if (pend_q[i] && !taken_c[i]) drop_sum_c = drop_sum_c + SUM_W'(1);
                pend_d[i]      = 1'b1;
                slot_data_d[i] = ch_data[i*DATA_W +: DATA_W];
                slot_ts_d[i]   = ts_q;
            end
            if (!ch_mask[i] || !detect_c) pend_d[i] = 1'b0;
        end
        drop_tot_c = SUM_W'(drop_q) + drop_sum_c;
        drop_d     = (drop_tot_c > SUM_W'(DROP_MAX)) ? DROP_MAX : DROP_W'(drop_tot_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ts_q    <= '0;
            pend_q  <= '0;
            drop_q  <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                snap_q[i]      <= '0;
                slot_data_q[i] <= '0;
                slot_ts_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            pend_q      <= pend_d;
            drop_q      <= drop_d;
            snap_q      <= snap_d;
            slot_data_q <= slot_data_d;
            slot_ts_q   <= slot_ts_d;
        end
    end

    rwl_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .din   (push_ev_c),
        .full  (fifo_full),
        .pop   (pop_c),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign ev_valid = !fifo_empty;
    assign ev_chan  = fifo_dout[EV_W-1 -: CH_W];
    assign ev_ts    = fifo_dout[DATA_W +: TS_W];
    assign ev_data  = fifo_dout[DATA_W-1:0];
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_reg_watch_logger.sv
// Directed bench for reg_watch_logger: a default instance and a DEPTH=2,
// TS_W=4 instance, with accepted events captured into queues.
module tb_reg_watch_logger;

    typedef struct {
        int cyc;
        int chan;
        int ts;
        int data;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    // Instance A: defaults
    logic        rst_a, en_a, rdy_a, val_a;
    logic [63:0] data_a;
    logic [3:0]  mask_a;
    logic [1:0]  chan_a;
    logic [15:0] evd_a, ts_a;
    logic [7:0]  drop_a;
    logic [3:0]  lvl_a;

    // Instance B: DEPTH=2, TS_W=4
    logic        rst_b, en_b, rdy_b, val_b;
    logic [63:0] data_b;
    logic [3:0]  mask_b;
    logic [1:0]  chan_b;
    logic [15:0] evd_b;
    logic [3:0]  ts_b;
    logic [7:0]  drop_b;
    logic [1:0]  lvl_b;

    ev_t q_a[$];
    ev_t q_b[$];

    reg_watch_logger u_dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .ch_data(data_a), .ch_mask(mask_a),
        .ev_valid(val_a), .ev_ready(rdy_a), .ev_chan(chan_a), .ev_data(evd_a),
        .ev_ts(ts_a), .drop_cnt(drop_a), .fifo_level(lvl_a)
    );

    reg_watch_logger #(.DATA_W(16), .N_CH(4), .DEPTH(2), .TS_W(4)) u_dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .ch_data(data_b), .ch_mask(mask_b),
        .ev_valid(val_b), .ev_ready(rdy_b), .ev_chan(chan_b), .ev_data(evd_b),
        .ev_ts(ts_b), .drop_cnt(drop_b), .fifo_level(lvl_b)
    );

    // An event is accepted on the posedge following a negedge with valid && ready.
    always @(negedge clk) begin
        ev_t e;
        if (!rst_a && val_a && rdy_a) begin
            e.cyc = cyc; e.chan = int'(chan_a); e.ts = int'(ts_a); e.data = int'(evd_a);
            q_a.push_back(e);
        end
        if (!rst_b && val_b && rdy_b) begin
            e.cyc = cyc; e.chan = int'(chan_b); e.ts = int'(ts_b); e.data = int'(evd_b);
            q_b.push_back(e);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; en_a = 1'b0; rdy_a = 1'b0; data_a = '0; mask_a = 4'hF;
        rst_b = 1'b1; en_b = 1'b0; rdy_b = 1'b0; data_b = '0; mask_b = 4'hF;
        #50;
        check_eq("rst_valid", 32'(val_a), 32'd0);
        check_eq("rst_chan",  32'(chan_a), 32'd0);
        check_eq("rst_data",  32'(evd_a), 32'd0);
        check_eq("rst_ts",    32'(ts_a), 32'd0);
        check_eq("rst_drop",  32'(drop_a), 32'd0);
        check_eq("rst_level", 32'(lvl_a), 32'd0);
        #50;
        step(1);
        rst_a = 1'b0; rst_b = 1'b0; rdy_a = 1'b1;

        // Basic change: a0 0 -> 5 sampled with ts=10
        en_a = 1'b1;
        step(11);
        data_a[15:0] = 16'h0005;
        step(1);
        check_eq("lat_valid_lo", 32'(val_a), 32'd0);
        check_eq("lat_level_lo", 32'(lvl_a), 32'd0);
        step(1);
        check_eq("basic_valid", 32'(val_a), 32'd1);
        check_eq("basic_chan",  32'(chan_a), 32'd0);
        check_eq("basic_data",  32'(evd_a), 32'h0005);
        check_eq("basic_ts",    32'(ts_a), 32'd10);
        step(2);
        check_eq("basic_count", 32'(q_a.size()), 32'd1);
        check_eq("basic_drop",  32'(drop_a), 32'd0);
        check_eq("basic_idle",  32'(val_a), 32'd0);

        // Simultaneous changes on v0, sp, ra with ts=14
        data_a[31:16] = 16'h1234;
        data_a[47:32] = 16'h7FFC;
        data_a[63:48] = 16'h0040;
        step(6);
        check_eq("simul_count", 32'(q_a.size()), 32'd4);
        if (q_a.size() == 4) begin
            check_eq("simul_chan1", 32'(q_a[1].chan), 32'd1);
            check_eq("simul_chan2", 32'(q_a[2].chan), 32'd2);
            check_eq("simul_chan3", 32'(q_a[3].chan), 32'd3);
            check_eq("simul_data1", 32'(q_a[1].data), 32'h1234);
            check_eq("simul_data2", 32'(q_a[2].data), 32'h7FFC);
            check_eq("simul_data3", 32'(q_a[3].data), 32'h0040);
            for (int i = 1; i < 4; i++) check_eq("simul_ts", 32'(q_a[i].ts), 32'd14);
            check_eq("simul_gap12", 32'(q_a[2].cyc - q_a[1].cyc), 32'd1);
            check_eq("simul_gap23", 32'(q_a[3].cyc - q_a[2].cyc), 32'd1);
        end

        // Mask and disable
        mask_a = 4'b1110;
        data_a[15:0] = 16'h0009;
        step(4);
        check_eq("mask_noev", 32'(q_a.size()), 32'd4);
        en_a = 1'b0;
        step(1);
        data_a[47:32] = 16'h1111;
        step(3);
        check_eq("disable_noev", 32'(q_a.size()), 32'd4);
        en_a = 1'b1;
        step(6);
        check_eq("arm_noev", 32'(q_a.size()), 32'd4);
        check_eq("arm_valid", 32'(val_a), 32'd0);
        data_a[47:32] = 16'h2222;
        step(4);
        check_eq("rearm_count", 32'(q_a.size()), 32'd5);
        if (q_a.size() == 5) begin
            check_eq("rearm_chan", 32'(q_a[4].chan), 32'd2);
            check_eq("rearm_data", 32'(q_a[4].data), 32'h2222);
        end
        check_eq("mask_drop", 32'(drop_a), 32'd0);

        // Reset mid-drain with three queued events
        rdy_a = 1'b0;
        mask_a = 4'hF;
        data_a[31:16] = 16'h00A1;
        data_a[47:32] = 16'h00A2;
        data_a[63:48] = 16'h00A3;
        step(5);
        check_eq("drain_level", 32'(lvl_a), 32'd3);
        check_eq("drain_valid", 32'(val_a), 32'd1);
        #2;
        rst_a = 1'b1;
        #1;
        check_eq("async_valid", 32'(val_a), 32'd0);
        check_eq("async_level", 32'(lvl_a), 32'd0);
        check_eq("async_data",  32'(evd_a), 32'd0);
        step(1);
        rst_a = 1'b0;
        rdy_a = 1'b1;
        step(8);
        check_eq("stale_count", 32'(q_a.size()), 32'd5);
        check_eq("stale_valid", 32'(val_a), 32'd0);

        // Overwrite loss with DEPTH=2
        en_b = 1'b1;
        step(3);
        data_b[15:0] = 16'h0001; step(1);
        data_b[15:0] = 16'h0002; step(1);
        data_b[15:0] = 16'h0003; step(1);
        data_b[15:0] = 16'h0004; step(1);
        check_eq("ovw_level", 32'(lvl_b), 32'd2);
        check_eq("ovw_drop",  32'(drop_b), 32'd1);
        step(2);
        check_eq("ovw_hold_level", 32'(lvl_b), 32'd2);
        check_eq("ovw_head", 32'(evd_b), 32'h0001);
        rdy_b = 1'b1;
        step(6);
        check_eq("ovw_count", 32'(q_b.size()), 32'd3);
        if (q_b.size() == 3) begin
            check_eq("ovw_d0", 32'(q_b[0].data), 32'h0001);
            check_eq("ovw_d1", 32'(q_b[1].data), 32'h0002);
            check_eq("ovw_d2", 32'(q_b[2].data), 32'h0004);
        end
        check_eq("ovw_drop_end", 32'(drop_b), 32'd1);

        // Timestamp wrap with TS_W=4
        rst_b = 1'b1;
        step(1);
        rst_b = 1'b0;
        q_b.delete();
        step(16);
        data_b[47:32] = 16'h0015;
        step(2);
        data_b[31:16] = 16'h00AB;
        step(4);
        check_eq("wrap_count", 32'(q_b.size()), 32'd2);
        if (q_b.size() == 2) begin
            check_eq("wrap_chan0", 32'(q_b[0].chan), 32'd2);
            check_eq("wrap_ts15",  32'(q_b[0].ts), 32'd15);
            check_eq("wrap_chan1", 32'(q_b[1].chan), 32'd1);
            check_eq("wrap_ts1",   32'(q_b[1].ts), 32'd1);
        end

        // Drop counter saturation
        rdy_b = 1'b0;
        for (int i = 0; i < 300; i++) begin
            data_b[15:0] = 16'(i + 100);
            step(1);
        end
        step(2);
        check_eq("sat_drop",  32'(drop_b), 32'd255);
        check_eq("sat_level", 32'(lvl_b), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
